risc16_ctrl: RTL

- Multi-cycle control sequencer for the RiSC-16 datapath; sits directly upstream of the ALU.
- Drives func_alu and the operand, PC, register-file and memory strobes, and consumes the ALU's eq flag.
- Takes the latched instruction word from the datapath IR and sequences FETCH/DECODE/EXEC/MEM/WB over a ready-handshaked unified memory port.
- Also counts retired instructions.

---
 rtl/risc16_pkg.sv | 32 +++
 rtl/risc16_decode.sv | 25 ++
 rtl/risc16_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/risc16_pkg.sv
// risc16_pkg: shared opcodes, ALU function codes, sequencer states and mux encodings
package risc16_pkg;
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_NAND = 3'b010,
        OP_LUI  = 3'b011,
        OP_SW   = 3'b100,
        OP_LW   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_JALR = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

    localparam logic [1:0] FUNC_ADD  = 2'b00;
    localparam logic [1:0] FUNC_NAND = 2'b01;
    localparam logic [1:0] FUNC_PASS = 2'b10;
    localparam logic [1:0] FUNC_CMP  = 2'b11;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_ALU = 2'b10;

    localparam logic [1:0] WSRC_ALU = 2'b00;
    localparam logic [1:0] WSRC_MDR = 2'b01;
    localparam logic [1:0] WSRC_PC1 = 2'b10;

    localparam logic [1:0] RA2_RC = 2'b00;
    localparam logic [1:0] RA2_RB = 2'b01;
    localparam logic [1:0] RA2_RA = 2'b10;
endpackage

// File: rtl/risc16_decode.sv
// risc16_decode: classifies the instruction word for the control sequencer
module risc16_decode
    import risc16_pkg::*;
(
    input  logic [15:0] ir,
    output opcode_e     op,
    output logic        is_mem,
    output logic        is_store,
    output logic        is_branch,
    output logic        is_jalr,
    output logic        is_halt,
    output logic        writes_rf
);
    logic unused_imm;

    assign op        = opcode_e'(ir[15:13]);
    assign is_store  = op == OP_SW;
    assign is_mem    = is_store || op == OP_LW;
    assign is_branch = op == OP_BEQ;
    assign is_jalr   = op == OP_JALR;
    // JALR with a non-zero immediate field is the halt encoding
    assign is_halt   = is_jalr && ir[6:0] != 7'd0;
    assign writes_rf = !is_store && !is_branch && ir[12:10] != 3'd0;
    assign unused_imm = ^ir[9:7];
endmodule

// File: rtl/risc16_ctrl.sv
// risc16_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RiSC-16 datapath
module risc16_ctrl
    import risc16_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      ir,
    input  logic             eq,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             opnd_we,
    output logic             rf_ra1_sel,
    output logic [1:0]       rf_ra2_sel,
    output logic             alu_in1_sel,
    output logic             alu_in2_sel,
    output logic [1:0]       func_alu,
    output logic             aluout_we,
    output logic             mdr_we,
    output logic             rf_we,
    output logic [1:0]       rf_wsrc,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             retired,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             halted
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    opcode_e          op;
    logic             is_mem, is_store, is_branch, is_jalr, is_halt, writes_rf;

    risc16_decode u_decode (
        .ir        (ir),
        .op        (op),
        .is_mem    (is_mem),
        .is_store  (is_store),
        .is_branch (is_branch),
        .is_jalr   (is_jalr),
        .is_halt   (is_halt),
        .writes_rf (writes_rf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        opnd_we      = 1'b0;
        rf_ra1_sel   = 1'b0;
        rf_ra2_sel   = RA2_RC;
        alu_in1_sel  = 1'b0;
        alu_in2_sel  = 1'b0;
        func_alu     = FUNC_ADD;
        aluout_we    = 1'b0;
        mdr_we       = 1'b0;
        rf_we        = 1'b0;
        rf_wsrc      = WSRC_ALU;
        pc_we        = 1'b0;
        pc_src       = PC_INC;
        retired      = 1'b0;
        halted       = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                opnd_we    = 1'b1;
                rf_ra1_sel = is_branch;
                rf_ra2_sel = is_store ? RA2_RA : is_branch ? RA2_RB : RA2_RC;
                state_d    = is_halt ? HALT : EXEC;
            end
            EXEC: begin
                aluout_we   = 1'b1;
                alu_in1_sel = op == OP_LUI;
                alu_in2_sel = op == OP_ADDI || is_mem;
                func_alu    = op == OP_NAND ? FUNC_NAND :
                              (op == OP_LUI || is_jalr) ? FUNC_PASS :
                              is_branch ? FUNC_CMP : FUNC_ADD;
                pc_we       = is_branch;
                pc_src      = (is_branch && eq) ? PC_BR : PC_INC;
                retired     = is_branch;
                state_d     = is_branch ? FETCH : is_mem ? MEM : WB;
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                mdr_we       = mem_ready && !is_store;
                pc_we        = mem_ready && is_store;
                retired      = mem_ready && is_store;
                state_d      = !mem_ready ? MEM : is_store ? FETCH : WB;
            end
            WB: begin
                rf_we   = writes_rf;
                rf_wsrc = op == OP_LW ? WSRC_MDR : is_jalr ? WSRC_PC1 : WSRC_ALU;
                pc_we   = 1'b1;
                pc_src  = is_jalr ? PC_ALU : PC_INC;
                retired = 1'b1;
                state_d = FETCH;
            end
            HALT: halted = 1'b1;
            default: state_d = IDLE;
        endcase
        cnt_d = cnt_q + CNT_W'(retired);
    end

    assign retired_cnt = cnt_q;
endmodule
